// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A x D over BRAMs: issues A/D read addresses, multiply-accumulates
// the returned words and writes each C element to the result BRAM.
module matmul_seq_ctrl #(
  parameter int N      = 2,
  parameter int M      = 3,
  parameter int R      = 5,
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int BASE_A = 0,
  parameter int BASE_D = 0,
  parameter int BASE_C = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          wrA_done,
  input  logic          wrD_done,
  output logic [AW-1:0] addrbA,
  input  logic [DW-1:0] doutbA,
  output logic [AW-1:0] addrbD,
  input  logic [DW-1:0] doutbD,
  output logic          weC,
  output logic [AW-1:0] addrC,
  output logic [DW-1:0] dinC,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state_dbg
);

  // Handshake: start is a request sampled only in IDLE (ignored otherwise, never
  // queued); busy covers WAIT_LOAD..DONE; done is a 1-cycle completion pulse.

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (R > 1) ? $clog2(R) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(N - 1);
  localparam logic [KW-1:0] K_LAST = KW'(M - 1);
  localparam logic [JW-1:0] J_LAST = JW'(R - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOAD = 3'd1,
    RUN       = 3'd2,
    DRAIN     = 3'd3,
    WRITE     = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [KW-1:0]   k_q, k_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic            rd_vld_q;
  logic            rd_first_q;
  logic [AW-1:0]   addra_q;
  logic [AW-1:0]   addrd_q;
  logic [AW-1:0]   addrc_q;
  logic [DW-1:0]   dinc_q;

  logic [AW-1:0]   addr_a_cur;
  logic [AW-1:0]   addr_d_cur;
  logic [AW-1:0]   addr_c_cur;
  logic [DW-1:0]   product;

  // All address arithmetic is AW bits wide and wraps.
  assign addr_a_cur = AW'(BASE_A) + AW'(i_q * M) + AW'(k_q);
  assign addr_d_cur = AW'(BASE_D) + AW'(k_q * R) + AW'(j_q);
  assign addr_c_cur = AW'(BASE_C) + AW'(i_q * R) + AW'(j_q);
  assign product    = doutbA * doutbD;

  // Read data lags the address by one cycle, so accumulation is driven by a
  // one-cycle-delayed copy of "address issued" and "first term of element".
  always_comb begin
    acc_d = acc_q;
    if (rd_vld_q) begin
      acc_d = rd_first_q ? product : acc_q + product;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        if (wrA_done && wrD_done) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (k_q == K_LAST) state_d = DRAIN;
        else               k_d     = k_q + KW'(1);
      end
      DRAIN: begin
        state_d = WRITE;
      end
      WRITE: begin
        k_d     = '0;
        state_d = RUN;
        if (j_q == J_LAST) begin
          j_d = '0;
          if (i_q == I_LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      addra_q    <= '0;
      addrd_q    <= '0;
      addrc_q    <= '0;
      dinc_q     <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      rd_vld_q   <= (state_q == RUN);
      rd_first_q <= (state_q == RUN) && (k_q == '0);
      if (state_q == RUN) begin
        addra_q <= addr_a_cur;
        addrd_q <= addr_d_cur;
      end
      // DRAIN folds in the last term; latch the finished element for WRITE.
      if (state_q == DRAIN) begin
        addrc_q <= addr_c_cur;
        dinc_q  <= acc_d;
      end
    end
  end

  assign addrbA    = (state_q == RUN) ? addr_a_cur : addra_q;
  assign addrbD    = (state_q == RUN) ? addr_d_cur : addrd_q;
  assign addrC     = addrc_q;
  assign dinC      = dinc_q;
  assign weC       = (state_q == WRITE) && !reset;
  assign busy      = (state_q != IDLE) && !reset;
  assign done      = (state_q == DONE) && !reset;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: BRAM read models, expected-write queue filled from a
// reference product, directed scenarios, one summary line.
module tb_matmul_seq_ctrl;

  localparam int N  = 2;
  localparam int M  = 3;
  localparam int R  = 5;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          start_w = 1'b0;
  logic          wrA_done = 1'b1;
  logic          wrD_done = 1'b1;

  logic [AW-1:0] addrbA, addrbD, addrC;
  logic [DW-1:0] doutbA, doutbD, dinC;
  logic          weC, busy, done;
  logic [2:0]    state_dbg;

  logic [AW-1:0] addrbA_w, addrbD_w, addrC_w;
  logic [DW-1:0] doutbA_w, doutbD_w, dinC_w;
  logic          weC_w, busy_w, done_w;
  logic [2:0]    state_dbg_w;

  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_d [256];

  matmul_seq_ctrl #(.N(N), .M(M), .R(R), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .wrA_done(wrA_done), .wrD_done(wrD_done),
    .addrbA(addrbA), .doutbA(doutbA), .addrbD(addrbD), .doutbD(doutbD),
    .weC(weC), .addrC(addrC), .dinC(dinC), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  matmul_seq_ctrl #(.N(N), .M(M), .R(R), .AW(AW), .DW(DW), .BASE_C(250)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .wrA_done(wrA_done), .wrD_done(wrD_done),
    .addrbA(addrbA_w), .doutbA(doutbA_w), .addrbD(addrbD_w), .doutbD(doutbD_w),
    .weC(weC_w), .addrC(addrC_w), .dinC(dinC_w), .busy(busy_w), .done(done_w),
    .state_dbg(state_dbg_w)
  );

  // Synchronous-read BRAM ports: data appears one cycle after the address.
  always @(posedge clk) begin
    doutbA   <= mem_a[addrbA];
    doutbD   <= mem_d[addrbD];
    doutbA_w <= mem_a[addrbA_w];
    doutbD_w <= mem_d[addrbD_w];
  end

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    obs_c [10];
  int n_err    = 0;
  int n_checks = 0;
  int x_seen   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] model_c(input int i, input int j);
    logic [DW-1:0] acc;
    logic [DW-1:0] a;
    logic [DW-1:0] d;
    acc = '0;
    for (int k = 0; k < M; k++) begin
      a   = mem_a[(i * M + k) % 256];
      d   = mem_d[(k * R + j) % 256];
      acc = acc + a * d;
    end
    return acc;
  endfunction

  task automatic push_run(input int base_c);
    logic [AW-1:0] ad;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < R; j++) begin
        ad = AW'((base_c + i * R + j) % 256);
        exp_q.push_back({ad, model_c(i, j)});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_default();
    for (int n = 0; n < 256; n++) begin
      mem_a[n] = (n < 6) ? DW'(n + 1) : '0;
      mem_d[n] = (n >= 1 && n < 15) ? DW'(10 * n + 5) : '0;
    end
  endtask

  task automatic pulse_start(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = hold;
  endtask

  // Runs the main DUT until done_target done pulses (or stop_wr writes), comparing
  // every write against the expected queue.
  task automatic run_collect(input int done_target, input int stop_wr, input int pulse_at,
                             input bit hold, output int nwr, output int ndone,
                             output int run1, output int last_wr, output int gap);
    logic [AW+DW-1:0] e;
    int cyc;
    int done1;
    int run2;
    cyc = 0; nwr = 0; ndone = 0; run1 = -1; last_wr = -1; done1 = -1; run2 = -1; gap = -1;
    while (ndone < done_target && cyc < 400 && !(stop_wr > 0 && nwr >= stop_wr)) begin
      @(negedge clk);
      cyc++;
      start = hold || (cyc == pulse_at);
      if ($isunknown({addrbA, addrbD, weC, addrC, dinC, busy, done})) x_seen++;
      if (state_dbg == ST_RUN && run1 < 0) run1 = cyc;
      if (state_dbg == ST_RUN && ndone == 1 && run2 < 0) run2 = cyc;
      if (weC) begin
        nwr++;
        last_wr = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(addrC), 64'(e[AW+DW-1:DW]));
          chk("wr_data", 64'(dinC), 64'(e[DW-1:0]));
        end
        if (addrC < 10) obs_c[addrC] = dinC;
      end
      if (done) begin
        ndone++;
        if (done1 < 0) done1 = cyc;
        chk("done_after_last_write", 64'(cyc - last_wr), 1);
        if (ndone == done_target) start = 1'b0;
      end
    end
    if (run2 >= 0) gap = run2 - done1;
    if (stop_wr == 0 && ndone < done_target) chk("timeout", 64'(ndone), 64'(done_target));
  endtask

  task automatic quiet_tail(input string tag);
    int extra;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (weC || done) extra++;
    end
    chk(tag, 64'(extra), 0);
  endtask

  // ---------------- directed sequence ----------------
  int nwr, ndone, run1, last_wr, gap, viol, nw, first_a, last_a, cyc;
  logic [DW-1:0] last_d;

  initial begin
    load_default();
    for (int n = 0; n < 10; n++) obs_c[n] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, weC, addrbA, addrbD, addrC, dinC}), 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic product
    push_run(0);
    pulse_start(1'b0);
    chk("busy_after_start", 64'(busy), 1);
    run_collect(1, 0, -1, 1'b0, nwr, ndone, run1, last_wr, gap);
    chk("basic_writes", 64'(nwr), 10);
    chk("basic_span", 64'(last_wr - run1 + 1), 50);
    chk("c0", 64'(obs_c[0]), 425);
    chk("c1", 64'(obs_c[1]), 490);
    chk("c4", 64'(obs_c[4]), 670);
    chk("c5", 64'(obs_c[5]), 905);
    chk("c9", 64'(obs_c[9]), 1525);
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 0);

    // Load not finished: nothing moves until wrD_done rises
    wrD_done = 1'b0;
    push_run(0);
    pulse_start(1'b0);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (weC || addrbA != 8'd5 || addrbD != 8'd14 || !busy) viol++;
    end
    chk("wait_load_quiet", 64'(viol), 0);
    wrD_done = 1'b1;
    run_collect(1, 0, -1, 1'b0, nwr, ndone, run1, last_wr, gap);
    chk("waitload_writes", 64'(nwr), 10);
    chk("waitload_span", 64'(last_wr - run1 + 1), 50);

    // Reset during the 4th element's RUN
    push_run(0);
    pulse_start(1'b0);
    run_collect(1, 3, -1, 1'b0, nwr, ndone, run1, last_wr, gap);
    @(negedge clk);
    chk("in_run_before_reset", 64'(state_dbg), 64'(ST_RUN));
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_outputs", 64'({busy, done, weC, addrbA, addrbD, addrC, dinC}), 0);
    reset = 1'b0;
    exp_q.delete();
    push_run(0);
    pulse_start(1'b0);
    run_collect(1, 0, -1, 1'b0, nwr, ndone, run1, last_wr, gap);
    chk("after_reset_writes", 64'(nwr), 10);

    // Second start mid-run is ignored
    push_run(0);
    pulse_start(1'b0);
    run_collect(1, 0, 15, 1'b0, nwr, ndone, run1, last_wr, gap);
    chk("ignore_writes", 64'(nwr), 10);
    quiet_tail("ignore_no_rerun");

    // Start held high: back-to-back runs
    push_run(0);
    push_run(0);
    pulse_start(1'b1);
    run_collect(2, 0, -1, 1'b1, nwr, ndone, run1, last_wr, gap);
    chk("held_writes", 64'(nwr), 20);
    chk("held_dones", 64'(ndone), 2);
    chk("held_gap", 64'(gap), 3);
    quiet_tail("held_stops");
    chk("queue_drained", 64'(exp_q.size()), 0);

    // Saturated operands: low word of each product is 1
    for (int n = 0; n < 256; n++) begin
      mem_a[n] = '1;
      mem_d[n] = '1;
    end
    push_run(0);
    x_seen = 0;
    pulse_start(1'b0);
    run_collect(1, 0, -1, 1'b0, nwr, ndone, run1, last_wr, gap);
    chk("ff_c9", 64'(obs_c[9]), 3);
    chk("ff_no_x", 64'(x_seen), 0);

    // Result address wrap with BASE_C = 250
    load_default();
    @(negedge clk);
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    nw = 0; first_a = -1; last_a = -1; last_d = '0; cyc = 0;
    while (!done_w && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (weC_w) begin
        nw++;
        if (first_a < 0) first_a = int'(addrC_w);
        last_a = int'(addrC_w);
        last_d = dinC_w;
      end
    end
    chk("wrap_done_seen", 64'(done_w), 1);
    chk("wrap_writes", 64'(nw), 10);
    chk("wrap_first_addr", 64'(first_a), 250);
    chk("wrap_last_addr", 64'(last_a), 3);
    chk("wrap_last_data", 64'(last_d), 1525);
    @(negedge clk);
    chk("wrap_idle", 64'({busy_w, state_dbg_w}), 64'(ST_IDLE));

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
